popcount_window_acc: RTL and testbench

//   Downstream stage of the single512 compressor. Consumes one popcount per

---
 rtl/popcount_window_acc.sv | 137 +++++++++++++
 tb/tb_popcount_window_acc.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_window_acc.sv
// popcount_window_acc
//   Accumulates a window of WINDOW popcount samples coming from the
//   compressor stage. It reports the sum, minimum and maximum of each
//   completed window and keeps a sticky flag for out-of-range counts.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      begin a new window (honoured only while idle)
//   in_valid   comp_in carries a sample this cycle
//   comp_in    popcount sample, CNT_W bits, unsigned
//   busy       1 while a window is being accumulated
//   done       one-cycle pulse when a window completes
//   sum_out    sum of the last completed window
//   min_out    minimum sample of the last completed window
//   max_out    maximum sample of the last completed window
//   range_err  sticky: a sample above MAX_COUNT was accepted
module popcount_window_acc #(
    parameter int CNT_W     = 10,
    parameter int WINDOW    = 256,
    parameter int MAX_COUNT = 512,
    parameter int SUM_W     = CNT_W + $clog2(WINDOW)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [CNT_W-1:0] comp_in,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sum_out,
    output logic [CNT_W-1:0] min_out,
    output logic [CNT_W-1:0] max_out,
    output logic             range_err
);

    localparam int IDX_W = $clog2(WINDOW);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SUM_W-1:0] acc_sum, sum_next;
    logic [CNT_W-1:0] acc_min, min_next;
    logic [CNT_W-1:0] acc_max, max_next;
    logic [IDX_W-1:0] cnt;
    logic             accept;
    logic             last;

    function automatic logic [CNT_W-1:0] umin(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
        return (b < a) ? b : a;
    endfunction

    function automatic logic [CNT_W-1:0] umax(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
        return (b > a) ? b : a;
    endfunction

    function automatic logic out_of_range(input logic [CNT_W-1:0] v);
        return int'(v) > MAX_COUNT;
    endfunction

    // Datapath for the sample being accepted this cycle; the final window
    // results are taken from these so they include the last sample.
    always_comb begin
        accept   = (state == S_ACCUM) && in_valid;
        last     = accept && (cnt == IDX_W'(WINDOW - 1));
        sum_next = acc_sum + SUM_W'(comp_in);
        min_next = umin(acc_min, comp_in);
        max_next = umax(acc_max, comp_in);
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_ACCUM;
            S_ACCUM: if (last)  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum_out   <= '0;
            min_out   <= '0;
            max_out   <= '0;
            range_err <= 1'b0;
            acc_sum   <= '0;
            acc_min   <= '0;
            acc_max   <= '0;
            cnt       <= '0;
        end else begin
            state <= state_next;
            // busy and done are decoded from the next state so they line up
            // with the registered state rather than lagging it by a cycle.
            busy  <= (state_next == S_ACCUM);
            done  <= (state_next == S_DONE);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc_sum   <= '0;
                        acc_min   <= '1;
                        acc_max   <= '0;
                        cnt       <= '0;
                        range_err <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        acc_sum <= sum_next;
                        acc_min <= min_next;
                        acc_max <= max_next;
                        cnt     <= cnt + IDX_W'(1);
                        if (out_of_range(comp_in)) range_err <= 1'b1;
                        if (last) begin
                            sum_out <= sum_next;
                            min_out <= min_next;
                            max_out <= max_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_window_acc.sv
module tb_popcount_window_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance: WINDOW=4. Big instance: default parameters.
    logic        rst_s, start_s, valid_s;
    logic [9:0]  din_s;
    logic        busy_s, done_s, err_s;
    logic [11:0] sum_s;
    logic [9:0]  min_s, max_s;

    logic        rst_b, start_b, valid_b;
    logic [9:0]  din_b;
    logic        busy_b, done_b, err_b;
    logic [17:0] sum_b;
    logic [9:0]  min_b, max_b;

    popcount_window_acc #(.WINDOW(4)) u_small (
        .clk(clk), .reset(rst_s), .start(start_s), .in_valid(valid_s),
        .comp_in(din_s), .busy(busy_s), .done(done_s), .sum_out(sum_s),
        .min_out(min_s), .max_out(max_s), .range_err(err_s)
    );

    popcount_window_acc u_big (
        .clk(clk), .reset(rst_b), .start(start_b), .in_valid(valid_b),
        .comp_in(din_b), .busy(busy_b), .done(done_b), .sum_out(sum_b),
        .min_out(min_b), .max_out(max_b), .range_err(err_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_done_s = 0;
    logic chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Behavioural model: collect the accepted samples of a window, then
    // derive sum/min/max from the whole list once the window is full.
    int     m_phase [2];
    int     m_n     [2];
    int     m_buf   [2][256];
    logic   e_busy  [2];
    logic   e_done  [2];
    logic   e_err   [2];
    longint e_sum   [2];
    longint e_min   [2];
    longint e_max   [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_n[k] = 0; e_busy[k] = 0; e_done[k] = 0;
            e_err[k] = 0; e_sum[k] = 0; e_min[k] = 0; e_max[k] = 0;
        end
    end

    task automatic model_step(input int k, input logic r, input logic st,
                              input logic iv, input logic [9:0] d);
        int win;
        longint s, mn, mx;
        win = (k == 0) ? 4 : 256;
        if (r) begin
            m_phase[k] = 0; m_n[k] = 0; e_busy[k] = 0; e_done[k] = 0;
            e_err[k] = 0; e_sum[k] = 0; e_min[k] = 0; e_max[k] = 0;
        end else if (m_phase[k] == 0) begin
            e_done[k] = 0;
            if (st) begin
                m_phase[k] = 1; m_n[k] = 0; e_err[k] = 0; e_busy[k] = 1;
            end
        end else if (m_phase[k] == 1) begin
            if (iv) begin
                m_buf[k][m_n[k]] = int'(d);
                m_n[k]++;
                if (int'(d) > 512) e_err[k] = 1;
                if (m_n[k] == win) begin
                    s = 0; mn = m_buf[k][0]; mx = m_buf[k][0];
                    for (int i = 0; i < win; i++) begin
                        s += m_buf[k][i];
                        if (m_buf[k][i] < mn) mn = m_buf[k][i];
                        if (m_buf[k][i] > mx) mx = m_buf[k][i];
                    end
                    e_sum[k] = s; e_min[k] = mn; e_max[k] = mx;
                    e_busy[k] = 0; e_done[k] = 1; m_phase[k] = 2;
                end
            end
        end else begin
            e_done[k] = 0;
            m_phase[k] = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst_s, start_s, valid_s, din_s);
        model_step(1, rst_b, start_b, valid_b, din_b);
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (done_s === 1'b1) n_done_s++;
        if (chk_en) begin
            check("s_busy", 64'(busy_s), 64'(e_busy[0]));
            check("s_done", 64'(done_s), 64'(e_done[0]));
            check("s_sum",  64'(sum_s),  e_sum[0]);
            check("s_min",  64'(min_s),  e_min[0]);
            check("s_max",  64'(max_s),  e_max[0]);
            check("s_err",  64'(err_s),  64'(e_err[0]));
            check("b_busy", 64'(busy_b), 64'(e_busy[1]));
            check("b_done", 64'(done_b), 64'(e_done[1]));
            check("b_sum",  64'(sum_b),  e_sum[1]);
            check("b_min",  64'(min_b),  e_min[1]);
            check("b_max",  64'(max_b),  e_max[1]);
            check("b_err",  64'(err_b),  64'(e_err[1]));
        end
    end

    task automatic cyc_s(input logic st, input logic iv, input logic [9:0] d);
        @(negedge clk);
        start_s = st; valid_s = iv; din_s = d;
    endtask

    task automatic cyc_b(input logic st, input logic iv, input logic [9:0] d);
        @(negedge clk);
        start_b = st; valid_b = iv; din_b = d;
    endtask

    task automatic window_s(input logic [9:0] a, input logic [9:0] b,
                            input logic [9:0] c, input logic [9:0] d);
        cyc_s(1, 0, 0);
        cyc_s(0, 1, a); cyc_s(0, 1, b); cyc_s(0, 1, c); cyc_s(0, 1, d);
        cyc_s(0, 0, 0);
    endtask

    int d0;

    initial begin
        rst_s = 1; start_s = 0; valid_s = 0; din_s = 0;
        rst_b = 1; start_b = 0; valid_b = 0; din_b = 0;
        @(negedge clk); @(negedge clk);
        chk_en = 1;
        check("rst_busy", 64'(busy_s), 0);
        check("rst_sum",  64'(sum_s), 0);
        check("rst_min",  64'(min_b), 0);
        check("rst_err",  64'(err_s), 0);
        rst_s = 0; rst_b = 0;

        // in_valid in IDLE without start is ignored
        cyc_s(0, 1, 9); cyc_s(0, 0, 0); cyc_s(0, 0, 0);
        check("idle_busy", 64'(busy_s), 0);

        // 1: consecutive samples
        d0 = n_done_s;
        window_s(1, 2, 3, 4);
        check("t1_done", 64'(done_s), 1);
        check("t1_sum", 64'(sum_s), 10);
        check("t1_min", 64'(min_s), 1);
        check("t1_max", 64'(max_s), 4);
        check("t1_err", 64'(err_s), 0);
        cyc_s(0, 0, 0);
        check("t1_ndone", 64'(n_done_s - d0), 1);

        // 2: gaps of three idle cycles
        d0 = n_done_s;
        cyc_s(1, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc_s(0, 1, 10'(i));
            if (i < 4) begin
                cyc_s(0, 0, 0); cyc_s(0, 0, 0); cyc_s(0, 0, 0);
                check("t2_busy_gap", 64'(busy_s), 1);
            end
        end
        cyc_s(0, 0, 0);
        check("t2_sum", 64'(sum_s), 10);
        check("t2_max", 64'(max_s), 4);
        cyc_s(0, 0, 0); cyc_s(0, 0, 0);
        check("t2_ndone", 64'(n_done_s - d0), 1);

        // 3: default params, full-scale and zero windows
        cyc_b(1, 0, 0);
        for (int i = 0; i < 256; i++) cyc_b(0, 1, 10'd512);
        cyc_b(0, 0, 0);
        check("t3_done", 64'(done_b), 1);
        check("t3_sum", 64'(sum_b), 131072);
        check("t3_min", 64'(min_b), 512);
        check("t3_max", 64'(max_b), 512);
        check("t3_err", 64'(err_b), 0);
        cyc_b(0, 0, 0);
        cyc_b(1, 0, 0);
        for (int i = 0; i < 256; i++) cyc_b(0, 1, 10'd0);
        cyc_b(0, 0, 0);
        check("t3z_sum", 64'(sum_b), 0);
        check("t3z_min", 64'(min_b), 0);
        check("t3z_max", 64'(max_b), 0);
        cyc_b(0, 0, 0);

        // 4: out-of-range sample
        window_s(5, 600, 7, 8);
        check("t4_sum", 64'(sum_s), 620);
        check("t4_max", 64'(max_s), 600);
        check("t4_min", 64'(min_s), 5);
        cyc_s(0, 0, 0); cyc_s(0, 0, 0);
        check("t4_err_sticky", 64'(err_s), 1);
        cyc_s(1, 0, 0); cyc_s(0, 0, 0);
        check("t4_err_clear", 64'(err_s), 0);
        check("t4_hold_sum", 64'(sum_s), 620);
        cyc_s(0, 1, 1); cyc_s(0, 1, 1); cyc_s(0, 1, 1); cyc_s(0, 1, 1);
        cyc_s(0, 0, 0); cyc_s(0, 0, 0);

        // 5: reset mid-window
        d0 = n_done_s;
        cyc_s(1, 0, 0); cyc_s(0, 1, 50); cyc_s(0, 1, 60);
        @(negedge clk); valid_s = 0; rst_s = 1;
        @(negedge clk); rst_s = 0;
        check("t5_busy", 64'(busy_s), 0);
        check("t5_sum", 64'(sum_s), 0);
        check("t5_max", 64'(max_s), 0);
        cyc_s(0, 0, 0); cyc_s(0, 0, 0);
        check("t5_ndone", 64'(n_done_s - d0), 0);
        window_s(30, 10, 40, 20);
        check("t5_sum2", 64'(sum_s), 100);
        check("t5_min2", 64'(min_s), 10);
        check("t5_max2", 64'(max_s), 40);

        // 6: start ignored in ACCUM and DONE
        cyc_s(0, 0, 0);
        d0 = n_done_s;
        cyc_s(1, 0, 0);
        cyc_s(0, 1, 100); cyc_s(1, 1, 3); cyc_s(1, 0, 0);
        cyc_s(0, 1, 7); cyc_s(0, 1, 200);
        cyc_s(1, 0, 0);
        check("t6_done", 64'(done_s), 1);
        check("t6_sum", 64'(sum_s), 310);
        check("t6_min", 64'(min_s), 3);
        cyc_s(0, 0, 0);
        cyc_s(0, 0, 0);
        check("t6_idle_busy", 64'(busy_s), 0);
        check("t6_ndone", 64'(n_done_s - d0), 1);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
